// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C register read/write engine driving SCL/SDA.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       rw,
  input  logic [7:0] slave_id,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       error,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  typedef enum logic [3:0] {IDLE, START, ADDR, RW, ACK1, MADDR, ACK2, WRITE, READ, ACK3, STOP} state_t;
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [1:0] phase;
  logic [2:0] bit_cnt;
  logic [7:0] id_q, addr_q, wdata_q, shreg;
  logic rw_q, tick, bit_end, sample, accept, last_bit, ack_bit;
  always_comb begin
    tick = div == DW'(CLK_DIV - 1);
    bit_end = tick && phase == 2'd3;
    sample = tick && phase == 2'd1;
    last_bit = bit_cnt == 3'd7;
    done = bit_end && state == STOP;
    req_ready = state == IDLE || done;
    accept = req_valid && req_ready;
    ack_bit = state == ACK1 || state == ACK2 || (state == ACK3 && !rw_q);
    // START/STOP bend the normal low-high-high-low SCL shape to frame the bus
    scl_o = state == IDLE || (state == START ? phase != 2'd3 :
            state == STOP ? phase != 2'd0 : phase == 2'd1 || phase == 2'd2);
    sda_oe = state == START ? phase[1] :
             state == STOP  ? !phase[1] :
             state == ADDR  ? !id_q[~bit_cnt] :
             state == RW    ? !rw_q :
             state == MADDR ? !addr_q[~bit_cnt] :
             state == WRITE && !wdata_q[~bit_cnt];
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? START : IDLE;
      START:   if (bit_end) state_n = ADDR;
      ADDR:    if (bit_end && last_bit) state_n = RW;
      RW:      if (bit_end) state_n = ACK1;
      ACK1:    if (bit_end) state_n = error ? STOP : MADDR;
      MADDR:   if (bit_end && last_bit) state_n = ACK2;
      ACK2:    if (bit_end) state_n = error ? STOP : rw_q ? READ : WRITE;
      WRITE,
      READ:    if (bit_end && last_bit) state_n = ACK3;
      ACK3:    if (bit_end) state_n = STOP;
      STOP:    if (bit_end) state_n = accept ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      div <= '0;
      phase <= '0;
      bit_cnt <= '0;
      id_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rw_q <= 1'b0;
      shreg <= '0;
      rdata <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      div <= (tick || state == IDLE) ? '0 : div + 1'b1;
      phase <= state == IDLE ? 2'd0 : tick ? phase + 2'd1 : phase;
      bit_cnt <= (bit_end && (state == ADDR || state == MADDR || state == WRITE || state == READ)) ? bit_cnt + 3'd1 : bit_cnt;
      if (accept) begin
        id_q <= slave_id;
        addr_q <= mem_addr;
        wdata_q <= wdata;
        rw_q <= rw;
        error <= 1'b0;
      end else if (sample && ack_bit && sda_i) error <= 1'b1;
      if (sample && state == READ) shreg <= {shreg[6:0], sda_i};
      if (bit_end && state == ACK3 && rw_q) rdata <= shreg;
    end
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: table-driven and randomized checks of two engines (CLK_DIV 4 and 1) against a bus-level slave model.
module tb_i2c_master_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst = 2'b11, req_valid = 2'b00, rw = 2'b00;
  logic [1:0][7:0] id = '0, addr = '0, wd = '0;
  wire [1:0] req_ready, done, error, scl, sda_oe, line;
  wire [1:0][7:0] rdata;
  logic [1:0] pull = 2'b00;
  assign line = ~(sda_oe | pull);
  i2c_master_ctrl #(.CLK_DIV(4)) dut0 (.clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .rw(rw[0]), .slave_id(id[0]), .mem_addr(addr[0]), .wdata(wd[0]), .rdata(rdata[0]), .done(done[0]),
    .error(error[0]), .scl_o(scl[0]), .sda_oe(sda_oe[0]), .sda_i(line[0]));
  i2c_master_ctrl #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .rw(rw[1]), .slave_id(id[1]), .mem_addr(addr[1]), .wdata(wd[1]), .rdata(rdata[1]), .done(done[1]),
    .error(error[1]), .scl_o(scl[1]), .sda_oe(sda_oe[1]), .sda_i(line[1]));

  function automatic int dv(input int k);
    return k == 0 ? 4 : 1;
  endfunction

  // slave configuration: address it answers, byte it returns, forced NACKs
  logic [1:0][7:0] s_id = '0, s_rd = '0;
  logic [1:0] s_n2 = 2'b00, s_n3 = 2'b00;
  logic [1:0] act = 2'b00, prev_scl = 2'b11, prev_line = 2'b11, hi_trk = 2'b00;
  int cnt [2] = '{0, 0};
  int hi_len [2] = '{0, 0};
  int bad_hi [2] = '{0, 0};
  logic [0:29] st [2];
  int rec_n [2][64];
  logic [0:29] rec_b [2][64];
  int wr [2] = '{0, 0};
  int rp [2] = '{0, 0};
  int n_chk = 0, n_fail = 0;
  logic [1:0][7:0] rd_model = '0;

  function automatic logic want(input int k, input int c);
    logic m, r;
    m = st[k][0:7] == s_id[k];
    r = st[k][8];
    if (c == 9) return m;
    if (c == 18) return m && !s_n2[k];
    if (c >= 19 && c <= 26) return m && r && !s_n2[k] && !s_rd[k][26-c];
    if (c == 27) return m && !r && !s_n2[k] && !s_n3[k];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (prev_scl[k] && scl[k] && prev_line[k] && !line[k]) begin
        act[k] = 1'b1; cnt[k] = 0; st[k] = '0; hi_trk[k] = 1'b0; pull[k] = 1'b0;
      end else if (prev_scl[k] && scl[k] && !prev_line[k] && line[k]) begin
        if (act[k]) begin
          rec_n[k][wr[k] % 64] = cnt[k] - 1;
          rec_b[k][wr[k] % 64] = st[k];
          wr[k]++;
        end
        act[k] = 1'b0; hi_trk[k] = 1'b0; pull[k] = 1'b0;
      end else if (!prev_scl[k] && scl[k]) begin
        if (act[k] && cnt[k] < 30) begin st[k][cnt[k]] = line[k]; cnt[k]++; end
        hi_trk[k] = act[k]; hi_len[k] = 1;
      end else if (prev_scl[k] && !scl[k]) begin
        if (hi_trk[k] && hi_len[k] != 2 * dv(k)) bad_hi[k]++;
        hi_trk[k] = 1'b0;
        if (act[k]) pull[k] = want(k, cnt[k]);
      end else if (scl[k]) hi_len[k]++;
      prev_scl[k] = scl[k];
      prev_line[k] = line[k];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  // expected SDA bit stream, latency and error derived from the bus protocol rules
  task automatic model(input int k, input logic r, input logic [7:0] i, a, w,
                       output logic [0:29] eb, output int en, output int cyc, output logic err);
    logic q [$];
    logic m;
    logic [7:0] d;
    m = i == s_id[k];
    for (int b = 7; b >= 0; b--) q.push_back(i[b]);
    q.push_back(r);
    q.push_back(!m);
    if (m) begin
      for (int b = 7; b >= 0; b--) q.push_back(a[b]);
      q.push_back(s_n2[k]);
      if (!s_n2[k]) begin
        d = r ? s_rd[k] : w;
        for (int b = 7; b >= 0; b--) q.push_back(d[b]);
        q.push_back(r ? 1'b1 : s_n3[k]);
      end
    end
    eb = '0;
    for (int b = 0; b < q.size(); b++) eb[b] = q[b];
    en = q.size();
    cyc = 4 * dv(k) * (q.size() + 2);
    err = !m || (m && s_n2[k]) || (m && !r && !s_n2[k] && s_n3[k]);
  endtask

  task automatic start(input int k, input logic r, input logic [7:0] i, a, w, input logic hold);
    int n = 0;
    rw[k] = r; id[k] = i; addr[k] = a; wd[k] = w; req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 200 * dv(k)) begin @(negedge clk); n++; end
    if (!req_ready[k]) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int exp_cyc, input logic exp_err, input logic [7:0] exp_rd,
                           input logic [0:29] eb, input int en, input string nm);
    int n = 1, busy = 0, lim = 130 * dv(k) + 20;
    while (!done[k] && n < lim) begin
      if (req_ready[k]) busy++;
      @(negedge clk);
      n++;
    end
    chk({nm, " done_cycle"}, n, exp_cyc);
    chk({nm, " ready_while_busy"}, busy, 0);
    chk({nm, " error"}, {31'd0, error[k]}, {31'd0, exp_err});
    chk({nm, " rdata"}, {24'd0, rdata[k]}, {24'd0, exp_rd});
    chk({nm, " ready_at_done"}, {31'd0, req_ready[k]}, 1);
    chk({nm, " bus_idle_at_done"}, {30'd0, scl[k], sda_oe[k]}, 2);
    if (rp[k] == wr[k]) chk({nm, " stream_present"}, 0, 1);
    else begin
      chk({nm, " stream_len"}, rec_n[k][rp[k] % 64], en);
      chk({nm, " stream_bits"}, {2'b00, rec_b[k][rp[k] % 64]}, {2'b00, eb});
      rp[k]++;
    end
    @(negedge clk);
    chk({nm, " done_one_cycle"}, {31'd0, done[k]}, 0);
  endtask

  typedef struct {
    int k; logic r; logic [7:0] i, a, w, sid, rd; logic n2, n3;
    int cyc; logic err; logic [7:0] erd;
  } vec_t;
  vec_t tab [8];

  initial begin
    logic [0:29] eb;
    int en, cyc;
    logic err;
    tab[0] = '{0, 1'b0, 8'h5A, 8'h10, 8'hC3, 8'h5A, 8'h00, 1'b0, 1'b0, 480, 1'b0, 8'h00};
    tab[1] = '{0, 1'b1, 8'h5A, 8'h22, 8'h00, 8'h5A, 8'hA5, 1'b0, 1'b0, 480, 1'b0, 8'hA5};
    tab[2] = '{0, 1'b0, 8'h33, 8'h10, 8'hC3, 8'h5A, 8'h00, 1'b0, 1'b0, 192, 1'b1, 8'hA5};
    tab[3] = '{0, 1'b1, 8'h5A, 8'h40, 8'h00, 8'h5A, 8'h11, 1'b1, 1'b0, 336, 1'b1, 8'hA5};
    tab[4] = '{0, 1'b0, 8'h5A, 8'h01, 8'h77, 8'h5A, 8'h00, 1'b0, 1'b1, 480, 1'b1, 8'hA5};
    tab[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 120, 1'b0, 8'h00};
    tab[6] = '{1, 1'b1, 8'hFF, 8'h7E, 8'h00, 8'hFF, 8'h3C, 1'b0, 1'b0, 120, 1'b0, 8'h3C};
    tab[7] = '{1, 1'b1, 8'h12, 8'h7E, 8'h00, 8'hFF, 8'h99, 1'b0, 1'b0, 48, 1'b1, 8'h3C};
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", {31'd0, req_ready[k]}, 1);
      chk("reset_bus", {30'd0, scl[k], sda_oe[k]}, 2);
      chk("reset_done_err", {30'd0, done[k], error[k]}, 0);
      chk("reset_rdata", {24'd0, rdata[k]}, 0);
    end
    rst = 2'b00;
    @(negedge clk);
    for (int t = 0; t < 8; t++) begin
      s_id[tab[t].k] = tab[t].sid; s_rd[tab[t].k] = tab[t].rd;
      s_n2[tab[t].k] = tab[t].n2; s_n3[tab[t].k] = tab[t].n3;
      model(tab[t].k, tab[t].r, tab[t].i, tab[t].a, tab[t].w, eb, en, cyc, err);
      start(tab[t].k, tab[t].r, tab[t].i, tab[t].a, tab[t].w, 1'b0);
      wait_done(tab[t].k, tab[t].cyc, tab[t].err, tab[t].erd, eb, en, $sformatf("vec%0d", t));
      rd_model[tab[t].k] = tab[t].erd;
    end
    // busy engine: a different request held high must wait for the done cycle
    s_id[0] = 8'h5A; s_n2[0] = 1'b0; s_n3[0] = 1'b0;
    model(0, 1'b0, 8'h5A, 8'h10, 8'hC3, eb, en, cyc, err);
    start(0, 1'b0, 8'h5A, 8'h10, 8'hC3, 1'b1);
    rw[0] = 1'b0; id[0] = 8'h5A; addr[0] = 8'h44; wd[0] = 8'h9E;
    wait_done(0, 480, 1'b0, rd_model[0], eb, en, "held_first");
    req_valid[0] = 1'b0;
    model(0, 1'b0, 8'h5A, 8'h44, 8'h9E, eb, en, cyc, err);
    wait_done(0, 480, 1'b0, rd_model[0], eb, en, "held_second");
    // reset in the middle of the memory-address byte
    start(0, 1'b0, 8'h5A, 8'h10, 8'hC3, 1'b0);
    for (int c = 1; c < 200; c++) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_bus", {30'd0, scl[0], sda_oe[0]}, 2);
    chk("abort_ready", {31'd0, req_ready[0]}, 1);
    chk("abort_done", {31'd0, done[0]}, 0);
    chk("abort_rdata", {24'd0, rdata[0]}, 0);
    rst[0] = 1'b0;
    repeat (4) @(negedge clk);
    rp[0] = wr[0];
    rd_model[0] = 8'h00;
    model(0, 1'b0, 8'h5A, 8'h77, 8'h12, eb, en, cyc, err);
    start(0, 1'b0, 8'h5A, 8'h77, 8'h12, 1'b0);
    wait_done(0, 480, 1'b0, 8'h00, eb, en, "after_abort");
    for (int t = 0; t < 12; t++) begin
      int k;
      logic r;
      logic [7:0] i, a, w;
      k = t % 2;
      s_id[k] = 8'($urandom);
      s_rd[k] = 8'($urandom);
      s_n2[k] = $urandom_range(0, 4) == 0;
      s_n3[k] = $urandom_range(0, 4) == 0;
      r = 1'($urandom);
      i = $urandom_range(0, 3) == 0 ? 8'($urandom) : s_id[k];
      a = 8'($urandom);
      w = 8'($urandom);
      model(k, r, i, a, w, eb, en, cyc, err);
      if (r && !err) rd_model[k] = s_rd[k];
      start(k, r, i, a, w, 1'b0);
      wait_done(k, cyc, err, rd_model[k], eb, en, $sformatf("rand%0d", t));
    end
    chk("scl_high_width_div4", bad_hi[0], 0);
    chk("scl_high_width_div1", bad_hi[1], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-master I2C transaction engine. Sits directly upstream of the I2C slave and drives SCL/SDA toward it.
- Accepts one register request (slave id, memory address, read/write, write data) from the APB-side bus.
- Serialises the request as: START, 8-bit id, R/W bit, ACK, 8-bit mem address, ACK, 8-bit data, ACK/NACK, STOP.
- Returns read data and an error flag.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period. Legal range is ≥1; one bit period is 4*CLK_DIV cycles.

Ports:
- clk  in  1  system clock; all logic is on posedge clk.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe; sampled only while req_ready=1.
- req_ready  out  1  high when idle and able to accept a request.
- rw  in  1  1 = read, 0 = write; captured on accept.
- slave_id  in  8  full 8-bit slave id; captured on accept.
- mem_addr  in  8  slave memory address; captured on accept.
- wdata  in  8  write data; captured on accept.
- rdata  out  8  last successfully read byte.
- done  out  1  one-cycle pulse at the end of every transaction.
- error  out  1  valid with done; 1 = NACK seen.
- scl_o  out  1  SCL, push-pull. No clock stretching is supported.
- sda_oe  out  1  1 = pull SDA low; 0 = release (line reads 1 via pull-up).
- sda_i  in  1  sampled SDA line.

Behaviour:
- Reset values: req_ready=1, rdata=0x00, done=0, error=0, scl_o=1, sda_oe=0, state=IDLE, all counters 0.
- Reset mid-transaction aborts immediately; no STOP is generated.
- Reset has priority over a simultaneous req_valid.

Accept rule:
- A request is accepted when req_valid && req_ready; all inputs are latched in that cycle.
- req_ready drops the next cycle and returns high in the cycle done pulses.
- req_valid while busy is ignored and not queued.

Bit timing:
- Each bit has 4 phases of CLK_DIV cycles: P0 SCL low, P1 SCL high, P2 SCL high, P3 SCL low.
- sda_oe changes only at the start of P0.
- sda_i is sampled on the last cycle of P1.

START (one bit period):
- P0/P1: SCL=1, SDA released.
- P2: sda_oe=1 while SCL high.
- P3: SCL=0.

STOP (one bit period):
- P0: SCL=0, sda_oe=1.
- P1: SCL=1.
- P2/P3: SCL=1, sda_oe=0.

State machine: IDLE → START → ADDR → RW → ACK1 → MADDR → ACK2 → {WRITE | READ} → ACK3 → STOP → IDLE.
- ADDR, MADDR, WRITE, READ: 8 bits each, MSB first, counted by a 3-bit bit counter.
- RW: drives captured rw.
- WRITE: drives wdata.
- ADDR, MADDR: drive slave_id and mem_addr respectively.
- ACK1, ACK2, and ACK3 on writes: sda_oe=0; sample sda_i. A 1 sets the error latch and goes directly to STOP after that bit.
- READ: sda_oe=0; shift sda_i MSB first into a shift register.
- ACK3 on reads: master sends NACK (sda_oe=0), so the slave returns to idle. rdata updates at the end of ACK3.
- rdata is unchanged on writes and on errored reads.

Completion and latency:
- Full transaction = START + 28 bit periods + STOP = 30 periods.
- Acceptance cycle is cycle 0. done and error are valid in cycle 120*CLK_DIV. scl_o=1 and sda_oe=0 from the end of STOP.
- NACK at ACK1 → done at cycle 48*CLK_DIV (12 periods).
- NACK at ACK2 → done at cycle 84*CLK_DIV (21 periods).
- error holds until the next accept, then clears.
- Counter widths: divider $clog2(CLK_DIV)+1 bits; phase counter 2 bits; bit counter 3 bits. Divider wraps to 0 at CLK_DIV-1.

Test Plan:
- Write, CLK_DIV=4, id=0x5A, addr=0x10, wdata=0xC3, slave model ACKs → SDA bits 01011010,0,[ack],00010000,[ack],11000011,[ack]; START and STOP shapes correct; done at cycle 480 with error=0; rdata stays 0x00.
- Read, id=0x5A, addr=0x22, slave returns 0xA5 → RW bit=1; master releases SDA during data and ACK3 (NACK); rdata=0xA5 at done (cycle 480); error=0.
- Wrong id 0x33, no slave ACK (sda_i=1) → STOP follows ACK1; done at cycle 192 with error=1; rdata unchanged.
- req_valid held high during a busy write with different fields → the second request is not accepted until the cycle done pulses; SDA bit stream matches the first request only.
- reset asserted mid-MADDR → next cycle: scl_o=1, sda_oe=0, req_ready=1, done=0; a new write completes in 480 cycles.
- CLK_DIV=1, write id=0xFF, addr=0x00, wdata=0x01 → done at cycle 120; each SCL high pulse is 2 cycles.
